orion_icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the orion_core instruction port (imem_*) and instruction slave port 1 of the SoC arbiter.
- On a hit, returns instruction words without a memory access.
- On a miss, refills a whole line with sequential single-word reads through the arbiter. Memory-side writes are never issued.
- Supports a whole-cache invalidate (fence.i).

---
 rtl/orion_icache_pkg.sv | 14 +
 rtl/orion_icache_array.sv | 55 +++++
 rtl/orion_icache.sv | 143 ++++++++++++++
 tb/tb_orion_icache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/orion_icache_pkg.sv
// rtl/orion_icache_pkg.sv - shared geometry defaults and state encoding for orion_icache
package orion_icache_pkg;

  localparam int ICACHE_NLINES     = 16;
  localparam int ICACHE_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    DONE
  } icache_state_t;

endpackage

// File: rtl/orion_icache_array.sv
// rtl/orion_icache_array.sv - tag/valid/data storage for orion_icache
// One synchronous write port, asynchronous read, single-cycle valid clear.
module orion_icache_array #(
  parameter  int DATAW      = 32,
  parameter  int TAGW       = 26,
  parameter  int NLINES     = 16,
  parameter  int LINE_WORDS = 4,
  localparam int IDXW       = $clog2(NLINES),
  localparam int OFFW       = $clog2(LINE_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic             tag_we_i,
  input  logic [IDXW-1:0]  widx_i,
  input  logic [OFFW-1:0]  woff_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic [TAGW-1:0]  wtag_i,
  input  logic [IDXW-1:0]  ridx_i,
  input  logic [OFFW-1:0]  roff_i,
  output logic [TAGW-1:0]  rtag_o,
  output logic             rvalid_o,
  output logic [DATAW-1:0] rdata_o
);

  logic [NLINES-1:0] valid_q;
  logic [TAGW-1:0]   tag_q  [NLINES];
  logic [DATAW-1:0]  data_q [NLINES*LINE_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (we_i && tag_we_i) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[{widx_i, woff_i}] <= wdata_i;
    end
    if (we_i && tag_we_i) begin
      tag_q[widx_i] <= wtag_i;
    end
  end

  assign rtag_o   = tag_q[ridx_i];
  assign rvalid_o = valid_q[ridx_i];
  assign rdata_o  = data_q[{ridx_i, roff_i}];

endmodule

// File: rtl/orion_icache.sv
// rtl/orion_icache.sv - direct-mapped read-only instruction cache with line refill
// and whole-cache invalidate.
module orion_icache
  import orion_icache_pkg::*;
#(
  parameter int ADDRW      = 32,
  parameter int DATAW      = 32,
  parameter int NLINES     = ICACHE_NLINES,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [ADDRW-1:0] core_addr_i,
  input  logic             core_valid_i,
  output logic [DATAW-1:0] core_rdata_o,
  output logic             core_resp_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic             mem_valid_o,
  input  logic [DATAW-1:0] mem_rdata_i,
  input  logic             mem_resp_i
);

  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int IDXW = $clog2(NLINES);
  localparam int TAGW = ADDRW - IDXW - OFFW - 2;

  icache_state_t      state_q, state_d;
  logic [ADDRW-3:0]   addr_q, addr_d;
  logic [OFFW-1:0]    cnt_q, cnt_d;
  logic               pflush_q, pflush_d;

  logic [OFFW-1:0]    off;
  logic [IDXW-1:0]    idx;
  logic [TAGW-1:0]    tag;
  logic [TAGW-1:0]    arr_tag;
  logic               arr_valid;
  logic [DATAW-1:0]   arr_rdata;
  logic               arr_clear;
  logic               arr_we;
  logic               arr_tag_we;
  logic               hit;

  assign off = addr_q[OFFW-1:0];
  assign idx = addr_q[OFFW+:IDXW];
  assign tag = addr_q[ADDRW-3-:TAGW];
  assign hit = arr_valid && (arr_tag == tag);

  orion_icache_array #(
    .DATAW      (DATAW),
    .TAGW       (TAGW),
    .NLINES     (NLINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (arr_clear),
    .we_i     (arr_we),
    .tag_we_i (arr_tag_we),
    .widx_i   (idx),
    .woff_i   (cnt_q),
    .wdata_i  (mem_rdata_i),
    .wtag_i   (tag),
    .ridx_i   (idx),
    .roff_i   (off),
    .rtag_o   (arr_tag),
    .rvalid_o (arr_valid),
    .rdata_o  (arr_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      pflush_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      pflush_q <= pflush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    pflush_d     = pflush_q;
    arr_clear    = 1'b0;
    arr_we       = 1'b0;
    arr_tag_we   = 1'b0;
    core_resp_o  = 1'b0;
    core_rdata_o = '0;
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;

    case (state_q)
      IDLE: begin
        // A flush deferred from a hit still lands here before the next lookup.
        arr_clear = flush_i || pflush_q;
        pflush_d  = 1'b0;
        if (core_valid_i) begin
          addr_d  = core_addr_i[ADDRW-1:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (flush_i) pflush_d = 1'b1;
        if (hit) begin
          core_resp_o  = 1'b1;
          core_rdata_o = arr_rdata;
          state_d      = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (flush_i) pflush_d = 1'b1;
        mem_valid_o = 1'b1;
        mem_addr_o  = {tag, idx, cnt_q, 2'b00};
        if (mem_resp_i) begin
          arr_we = 1'b1;
          cnt_d  = cnt_q + OFFW'(1);
          if (cnt_q == OFFW'(LINE_WORDS - 1)) begin
            arr_tag_we = 1'b1;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        core_resp_o  = 1'b1;
        core_rdata_o = arr_rdata;
        arr_clear    = pflush_q || flush_i;
        pflush_d     = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_orion_icache.sv
// tb/tb_orion_icache.sv - randomized scoreboard bench for orion_icache
module tb_orion_icache;

  localparam int NL = 16;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_valid = 1'b0;
  logic [31:0] core_rdata;
  logic        core_resp;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  orion_icache dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .core_addr_i  (core_addr),
    .core_valid_i (core_valid),
    .core_rdata_o (core_rdata),
    .core_resp_o  (core_resp),
    .mem_addr_o   (mem_addr),
    .mem_valid_o  (mem_valid),
    .mem_rdata_i  (mem_rdata),
    .mem_resp_i   (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          miss;
    logic [31:0] base;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          passed = 0;
  int          resp_count = 0;
  int          mresp_count = 0;
  int          cyc = 0;
  bit          mv[NL];
  logic [31:0] mt[NL];
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mval(input logic [31:0] a);
    if (a >= 32'h10 && a <= 32'h1C) return 32'hA0 + ((a - 32'h10) >> 2);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
  endtask

  // Memory side: every accepted word request is logged, answered after 1..3 cycles.
  initial begin : responder
    logic [31:0] a;
    int lat;
    forever begin
      @(negedge clk);
      if (mem_valid && !rst) begin
        a = mem_addr;
        req_q.push_back(a);
        lat = $urandom_range(1, 3);
        repeat (lat - 1) @(posedge clk);
        @(posedge clk);
        #1;
        if (mem_valid && !rst) begin
          mem_resp  = 1'b1;
          mem_rdata = mval(a);
          mresp_count++;
          @(posedge clk);
          #1;
          mem_resp = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && core_resp) begin
      resp_count++;
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(core_rdata == e.data, "rdata", core_rdata, e.data);
        if (e.miss) begin
          chk(req_q.size() == LW, "refill_count", req_q.size(), LW);
          for (int i = 0; i < req_q.size() && i < LW; i++)
            chk(req_q[i] == e.base + 32'(4 * i), "refill_addr", req_q[i], e.base + 32'(4 * i));
        end else begin
          chk(req_q.size() == 0, "hit_mem_reqs", req_q.size(), 32'd0);
          chk(cyc == e.acc, "hit_latency", cyc, e.acc);
        end
      end
      req_q.delete();
    end
  end

  // Caller is #1 after a posedge with the cache idle or leaving its response state.
  // mode: 0 plain, 1 flush coincident with request, 2 flush during refill (misses only).
  task automatic fetch(input logic [31:0] addr, input int mode);
    int   idx;
    logic [31:0] tg;
    bit   miss;
    exp_t x;
    int   start;
    if (mode == 1) model_clear();
    idx  = int'((addr >> 4) & 32'hF);
    tg   = addr >> 8;
    miss = !mv[idx] || (mt[idx] != tg);
    if (miss) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    if (mode == 2 && !miss) mode = 0;
    if (mode == 2) model_clear();
    core_addr  = addr;
    core_valid = 1'b1;
    flush      = (mode == 1);
    start      = resp_count;
    @(posedge clk);
    #1;
    flush  = 1'b0;
    x.data = mval(addr & ~32'h3);
    x.miss = miss;
    x.base = addr & ~32'hF;
    x.acc  = cyc;
    sb.push_back(x);
    if (mode == 2) begin
      for (int c = 0; c < 50 && !mem_valid; c++) begin
        @(posedge clk);
        #1;
      end
      chk(mem_valid, "flush_refill_wait", mem_valid, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    for (int c = 0; c < 300 && resp_count == start; c++) @(posedge clk);
    chk(resp_count != start, "resp_timeout", resp_count, start + 1);
    #1;
    core_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int start;
    int r;
    model_clear();
    #12;
    chk(core_resp == 1'b0, "rst_core_resp", core_resp, 32'd0);
    chk(core_rdata == 32'd0, "rst_core_rdata", core_rdata, 32'd0);
    chk(mem_valid == 1'b0, "rst_mem_valid", mem_valid, 32'd0);
    chk(mem_addr == 32'd0, "rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    fetch(32'h0000_0010, 0);
    fetch(32'h0000_0018, 0);
    fetch(32'h0000_0110, 0);
    fetch(32'h0000_0010, 0);
    flush_pulse();
    fetch(32'h0000_0014, 0);
    fetch(32'h0000_001E, 0);
    fetch(32'h0000_0110, 2);
    fetch(32'h0000_0110, 0);

    core_addr  = 32'h0000_0210;
    core_valid = 1'b1;
    @(posedge clk);
    #1;
    start = mresp_count;
    for (int c = 0; c < 100 && mresp_count < start + 2; c++) @(posedge clk);
    chk(mresp_count >= start + 2, "rst_wait_words", mresp_count, start + 2);
    #2;
    rst = 1'b1;
    #1;
    chk(mem_valid == 1'b0, "midrefill_rst_mem_valid", mem_valid, 32'd0);
    core_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    req_q.delete();
    model_clear();
    fetch(32'h0000_0210, 0);
    fetch(32'h0000_0214, 0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) flush_pulse();
      fetch($urandom_range(0, 1023), (r == 1) ? 1 : (r == 2) ? 2 : 0);
    end

    repeat (5) @(posedge clk);
    chk(sb.size() == 0, "sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
